// File: rtl/sampler_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sampler_mixer_pkg
// Purpose  : Shared types and helpers for the sampler voice mixer: the mixer
//            FSM state encoding, accumulator sizing, unity gain and signed
//            saturation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sampler_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_OUT   = 2'd3
    } mixer_state_t;

    // Product is SW+GW+1 bits; clog2(NV) guard bits make the sum of all
    // voices overflow-free before it is clamped.
    function automatic int acc_width(input int sw, input int gw, input int nv);
        return sw + gw + 1 + $clog2(nv);
    endfunction

    function automatic int unity_gain(input int gw);
        return 1 << (gw - 1);
    endfunction

    // Clamp a sign-extended value into the signed range of an sw-bit sample.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                      input int sw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sw - 1));
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sampler_voice_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sampler_voice_fifo
// Purpose  : Single-clock synchronous FIFO holding the stereo frames of one
//            voice. Full/empty come from an occupancy count so they are
//            glitch-free register decodes.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_push/i_data - write request and frame (ignored when full)
//            i_pop         - read request (ignored when empty)
//            o_data        - frame at the head of the FIFO
//            o_full/o_empty- occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module sampler_voice_fifo #(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sampler_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : sampler_voice_mixer
// Purpose  : Buffers NUM_VOICES AXI4-Stream stereo voices and, on each codec
//            sample request, pops one frame per enabled voice, scales it by
//            the voice gain, sums, saturates and writes one mixed frame.
//            sample_req in cycle 0 -> data_wr in cycle NUM_VOICES+2.
// Ports    : axi_clk, reset       - clock, synchronous active-high reset
//            s_axis_tvalid/tready/tdata - per-voice input streams
//            voice_en, voice_gain - mix enables and unsigned gains
//            sample_req           - request one mixed frame
//            clear_status         - clears sticky flags (set has priority)
//            data_out, data_wr    - mixed {left,right} frame and its strobe
//            busy                 - frame in progress
//            underrun             - sticky: enabled voice had no frame
//            req_overrun          - sticky: request arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module sampler_voice_mixer
    import sampler_mixer_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                axi_clk,
    input  logic                                reset,
    input  logic [NUM_VOICES-1:0]               s_axis_tvalid,
    output logic [NUM_VOICES-1:0]               s_axis_tready,
    input  logic [NUM_VOICES*2*SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_VOICES-1:0]               voice_en,
    input  logic [NUM_VOICES*GAIN_WIDTH-1:0]    voice_gain,
    input  logic                                sample_req,
    input  logic                                clear_status,
    output logic [2*SAMPLE_WIDTH-1:0]           data_out,
    output logic                                data_wr,
    output logic                                busy,
    output logic [NUM_VOICES-1:0]               underrun,
    output logic                                req_overrun
);
    localparam int c_FW = 2 * SAMPLE_WIDTH;
    localparam int c_PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int c_AW = acc_width(SAMPLE_WIDTH, GAIN_WIDTH, NUM_VOICES);
    localparam int c_IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    mixer_state_t            r_state;
    mixer_state_t            w_state_nxt;
    logic [c_IW-1:0]         r_idx;
    logic [NUM_VOICES-1:0]   r_en_sh;
    logic [GAIN_WIDTH-1:0]   r_gain_sh [NUM_VOICES];
    logic signed [c_AW-1:0]  r_acc_l;
    logic signed [c_AW-1:0]  r_acc_r;
    logic [c_FW-1:0]         r_data_out;
    logic [NUM_VOICES-1:0]   r_underrun;
    logic                    r_req_overrun;

    logic [c_FW-1:0]         w_head [NUM_VOICES];
    logic [NUM_VOICES-1:0]   w_full;
    logic [NUM_VOICES-1:0]   w_empty;
    logic [NUM_VOICES-1:0]   w_push;
    logic [NUM_VOICES-1:0]   w_pop;
    logic [NUM_VOICES-1:0]   w_underrun_set;

    // ------------------------------------------------------------------
    // Per-voice FIFOs; a voice is popped only in its own ACCUM slot.
    // ------------------------------------------------------------------
    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            logic w_slot;
            assign w_slot = (r_state == ST_ACCUM) && (r_idx == c_IW'(v)) && r_en_sh[v];
            assign w_push[v]         = s_axis_tvalid[v] & ~w_full[v];
            assign w_pop[v]          = w_slot & ~w_empty[v];
            assign w_underrun_set[v] = w_slot & w_empty[v];

            sampler_voice_fifo #(
                .DATA_WIDTH (c_FW),
                .DEPTH      (FIFO_DEPTH)
            ) u_fifo (
                .clk     (axi_clk),
                .rst     (reset),
                .i_push  (w_push[v]),
                .i_data  (s_axis_tdata[v*c_FW +: c_FW]),
                .i_pop   (w_pop[v]),
                .o_data  (w_head[v]),
                .o_full  (w_full[v]),
                .o_empty (w_empty[v])
            );
        end
    endgenerate

    assign s_axis_tready = ~w_full;

    // ------------------------------------------------------------------
    // Gain stage for the voice in the current ACCUM slot.
    // ------------------------------------------------------------------
    logic [c_FW-1:0]              w_sel_frame;
    logic                         w_sel_live;
    logic signed [SAMPLE_WIDTH-1:0] w_smp_l;
    logic signed [SAMPLE_WIDTH-1:0] w_smp_r;
    logic signed [c_PW-1:0]       w_gain_s;
    logic signed [c_PW-1:0]       w_prod_l;
    logic signed [c_PW-1:0]       w_prod_r;
    logic signed [c_AW-1:0]       w_add_l;
    logic signed [c_AW-1:0]       w_add_r;

    assign w_sel_frame = w_head[r_idx];
    assign w_sel_live  = r_en_sh[r_idx] & ~w_empty[r_idx];
    assign w_smp_l     = $signed(w_sel_frame[c_FW-1:SAMPLE_WIDTH]);
    assign w_smp_r     = $signed(w_sel_frame[SAMPLE_WIDTH-1:0]);
    assign w_gain_s    = $signed({{(SAMPLE_WIDTH+1){1'b0}}, r_gain_sh[r_idx]});
    assign w_prod_l    = c_PW'(w_smp_l) * w_gain_s;
    assign w_prod_r    = c_PW'(w_smp_r) * w_gain_s;
    // Arithmetic shift floors toward negative infinity; empty or disabled
    // voices contribute nothing.
    assign w_add_l = w_sel_live ? c_AW'(w_prod_l >>> (GAIN_WIDTH - 1)) : '0;
    assign w_add_r = w_sel_live ? c_AW'(w_prod_r >>> (GAIN_WIDTH - 1)) : '0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (sample_req) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (r_idx == c_IW'(NUM_VOICES - 1)) w_state_nxt = ST_SAT;
            ST_SAT:   w_state_nxt = ST_OUT;
            ST_OUT:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_en_sh       <= '0;
            r_acc_l       <= '0;
            r_acc_r       <= '0;
            r_data_out    <= '0;
            r_underrun    <= '0;
            r_req_overrun <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++)
                r_gain_sh[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sample_req) begin
                        r_idx   <= '0;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        // Shadow copies keep mid-frame control changes out of
                        // the frame in progress.
                        r_en_sh <= voice_en;
                        for (int i = 0; i < NUM_VOICES; i++)
                            r_gain_sh[i] <= voice_gain[i*GAIN_WIDTH +: GAIN_WIDTH];
                    end
                end
                ST_ACCUM: begin
                    r_acc_l <= r_acc_l + w_add_l;
                    r_acc_r <= r_acc_r + w_add_r;
                    r_idx   <= r_idx + c_IW'(1);
                end
                ST_SAT: begin
                    r_data_out <= {SAMPLE_WIDTH'(sat_signed(64'(r_acc_l), SAMPLE_WIDTH)),
                                   SAMPLE_WIDTH'(sat_signed(64'(r_acc_r), SAMPLE_WIDTH))};
                end
                default: ;
            endcase

            // A set event in the same cycle as clear_status wins.
            r_underrun    <= (clear_status ? '0 : r_underrun) | w_underrun_set;
            // Any request outside IDLE (including the OUT cycle) is dropped.
            r_req_overrun <= (clear_status ? 1'b0 : r_req_overrun) |
                             (sample_req & (r_state != ST_IDLE));
        end
    end

    assign data_out    = r_data_out;
    assign data_wr     = (r_state == ST_OUT);
    assign busy        = (r_state != ST_IDLE);
    assign underrun    = r_underrun;
    assign req_overrun = r_req_overrun;

endmodule
`default_nettype wire
